// File: rtl/ans_preamble_pkg.sv
// rtl/ans_preamble_pkg.sv - bin masks, mode encodings and FSM state for the preamble generator
package ans_preamble_pkg;

  // Bit n of each mask describes bin n, where sc = n - 32.
  localparam logic [63:0] STF_NZ     = 64'h0111_1110_1111_1100;
  localparam logic [63:0] STF_SIGN   = 64'h0000_0110_0110_1000;
  localparam logic [63:0] LLTF_NZ    = 64'h07FF_FFFE_FFFF_FFC0;
  localparam logic [63:0] HTLTF_NZ   = 64'h1FFF_FFFE_FFFF_FFF0;
  localparam logic [63:0] HTLTF_SIGN = 64'h1856_7D4C_0A60_5300;

  localparam logic [1:0] PRE_LSTF  = 2'd0;
  localparam logic [1:0] PRE_LLTF  = 2'd1;
  localparam logic [1:0] PRE_HTSTF = 2'd2;
  localparam logic [1:0] PRE_HTLTF = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } pre_state_t;

endpackage

// File: rtl/ans_preamble_sign_rom.sv
// rtl/ans_preamble_sign_rom.sv - per-bin nonzero/negative lookup for the selected preamble field
module ans_preamble_sign_rom
  import ans_preamble_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [5:0] addr,
  output logic       nz,
  output logic       neg
);

  // L-LTF shares the HT-LTF sign table; its narrower nonzero mask hides the extra bins.
  always_comb begin
    nz  = 1'b0;
    neg = 1'b0;
    case (mode)
      PRE_LSTF, PRE_HTSTF: begin
        nz  = STF_NZ[addr];
        neg = STF_SIGN[addr];
      end
      PRE_LLTF: begin
        nz  = LLTF_NZ[addr];
        neg = HTLTF_SIGN[addr];
      end
      default: begin
        nz  = HTLTF_NZ[addr];
        neg = HTLTF_SIGN[addr];
      end
    endcase
  end

endmodule

// File: rtl/ans_preamble_fd_gen.sv
// rtl/ans_preamble_fd_gen.sv - sequenced, back-pressured frequency-domain preamble source
module ans_preamble_fd_gen
  import ans_preamble_pkg::*;
#(
  parameter int IQ_W       = 16,
  parameter int NFFT_LOG2  = 6,
  parameter int REP_W      = 3,
  parameter int IFFT_ORDER = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [REP_W-1:0]  n_sym,
  input  logic [IQ_W-1:0]   stf_amp,
  input  logic [IQ_W-1:0]   ltf_amp,
  output logic              busy,
  output logic [2*IQ_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [REP_W-1:0]  m_tuser,
  output logic              done
);

  localparam int NBIN = 1 << NFFT_LOG2;
  typedef logic [NFFT_LOG2-1:0] bin_t;

  pre_state_t       state;
  bin_t             bin_q;
  bin_t             next_bin;
  logic [REP_W-1:0] sym_q;
  logic [REP_W-1:0] nsym_q;
  logic [1:0]       mode_q;
  logic [IQ_W-1:0]  stf_q;
  logic [IQ_W-1:0]  ltf_q;

  logic [1:0]        mode_sel;
  logic [IQ_W-1:0]   mag;
  logic [IQ_W-1:0]   sval;
  logic [5:0]        rom_addr;
  logic              rom_nz;
  logic              rom_neg;
  logic              is_stf;
  logic              accept;
  logic [2*IQ_W-1:0] beat_data;

  assign accept = (state == ST_IDLE) && start && (n_sym != '0);

  // The output register is loaded one beat ahead, so the lookup always targets the next bin;
  // in IDLE that is bin 0 with the not-yet-latched inputs.
  always_comb begin
    next_bin = (state == ST_RUN) ? bin_q + 1'b1 : '0;
    rom_addr = 6'(next_bin) ^ ((IFFT_ORDER != 0) ? 6'h20 : 6'h00);
    mode_sel = (state == ST_IDLE) ? mode : mode_q;
    is_stf   = (mode_sel == PRE_LSTF) || (mode_sel == PRE_HTSTF);
    if (state == ST_IDLE) begin
      mag = is_stf ? stf_amp : ltf_amp;
    end else begin
      mag = is_stf ? stf_q : ltf_q;
    end
    sval = rom_neg ? (~mag + IQ_W'(1)) : mag;
    if (!rom_nz) begin
      beat_data = '0;
    end else if (is_stf) begin
      beat_data = {sval, sval};
    end else begin
      beat_data = {sval, {IQ_W{1'b0}}};
    end
  end

  ans_preamble_sign_rom u_rom (
    .mode (mode_sel),
    .addr (rom_addr),
    .nz   (rom_nz),
    .neg  (rom_neg)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      bin_q    <= '0;
      sym_q    <= '0;
      nsym_q   <= '0;
      mode_q   <= PRE_LSTF;
      stf_q    <= '0;
      ltf_q    <= '0;
      busy     <= 1'b0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tuser  <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state    <= ST_RUN;
            mode_q   <= mode;
            nsym_q   <= n_sym;
            stf_q    <= stf_amp;
            ltf_q    <= ltf_amp;
            bin_q    <= '0;
            sym_q    <= '0;
            busy     <= 1'b1;
            m_tvalid <= 1'b1;
            m_tdata  <= beat_data;
            m_tlast  <= 1'b0;
            m_tuser  <= '0;
          end
        end
        ST_RUN: begin
          if (m_tready) begin
            if (bin_q == bin_t'(NBIN - 1)) begin
              if (sym_q == nsym_q - 1'b1) begin
                state    <= ST_FIN;
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                m_tdata  <= '0;
                done     <= 1'b1;
              end else begin
                sym_q   <= sym_q + 1'b1;
                m_tuser <= sym_q + 1'b1;
                bin_q   <= '0;
                m_tdata <= beat_data;
                m_tlast <= 1'b0;
              end
            end else begin
              bin_q   <= next_bin;
              m_tdata <= beat_data;
              m_tlast <= (next_bin == bin_t'(NBIN - 1));
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ans_preamble_fd_gen.sv
// tb/tb_ans_preamble_fd_gen.sv - self-checking bench for ans_preamble_fd_gen in both bin orders
module tb_ans_preamble_fd_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [1:0]  mode;
  logic [2:0]  n_sym;
  logic [15:0] stf_amp;
  logic [15:0] ltf_amp;
  logic        tready;

  logic        busy0, tv0, tl0, dn0;
  logic        busy1, tv1, tl1, dn1;
  logic [31:0] td0, td1;
  logic [2:0]  tu0, tu1;

  int checks = 0;
  int failures = 0;

  // Standard sequences: STF signs at sc = -24..24 step 4, LTF signs at sc = -26..26.
  int stf_pts [13] = '{1, -1, 1, -1, -1, 1, 0, -1, -1, 1, 1, 1, 1};
  int ltf_seq [53] = '{1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1, 1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1,
                       0,
                       1, -1, -1, 1, 1, -1, 1, -1, 1, -1, -1, -1, -1, -1, 1, 1, -1, -1, 1, -1, 1, -1, 1, 1, 1, 1};

  int          m_mode;
  logic [15:0] m_a, m_b;
  int          beat, total, stalls, tlast_cnt;
  bit          act = 0, done_pend = 0, mon_on = 0, rnd_rdy = 0;
  logic [31:0] cap0 [0:191];
  logic [31:0] cap1 [0:191];
  logic [2:0]  tucap [0:191];
  bit          ev;
  int          b;

  ans_preamble_fd_gen #(.IFFT_ORDER(0)) u0 (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .n_sym(n_sym),
    .stf_amp(stf_amp), .ltf_amp(ltf_amp), .busy(busy0), .m_tdata(td0),
    .m_tvalid(tv0), .m_tready(tready), .m_tlast(tl0), .m_tuser(tu0), .done(dn0));

  ans_preamble_fd_gen #(.IFFT_ORDER(1)) u1 (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .n_sym(n_sym),
    .stf_amp(stf_amp), .ltf_amp(ltf_amp), .busy(busy1), .m_tdata(td1),
    .m_tvalid(tv1), .m_tready(tready), .m_tlast(tl1), .m_tuser(tu1), .done(dn1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  function automatic logic [31:0] model(input int md, input logic [15:0] a, input logic [15:0] bb, input int bin);
    int sc;
    int s;
    logic [15:0] mag;
    logic [15:0] v;
    sc = bin - 32;
    s = 0;
    if (md == 0 || md == 2) begin
      mag = a;
      if (sc >= -24 && sc <= 24 && (sc % 4) == 0) s = stf_pts[(sc + 24) / 4];
    end else begin
      mag = bb;
      if (sc >= -26 && sc <= 26) s = ltf_seq[sc + 26];
      else if (md == 3 && (sc == -28 || sc == -27)) s = 1;
      else if (md == 3 && (sc == 27 || sc == 28)) s = -1;
    end
    v = (s > 0) ? mag : (s < 0) ? (16'h0 - mag) : 16'h0;
    return (md == 0 || md == 2) ? {v, v} : {v, 16'h0};
  endfunction

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = rnd_rdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  // Compare process: one expected beat stream drives both bin orders.
  always @(negedge clk) begin
    if (mon_on) begin
      ev = act && (beat < total);
      chk("tvalid0", 64'(tv0), 64'(ev));
      chk("tvalid1", 64'(tv1), 64'(ev));
      chk("done0", 64'(dn0), 64'(done_pend));
      chk("done1", 64'(dn1), 64'(done_pend));
      done_pend = 0;
      if (ev) begin
        b = beat % 64;
        chk("tdata0", 64'(td0), 64'(model(m_mode, m_a, m_b, b)));
        chk("tdata1", 64'(td1), 64'(model(m_mode, m_a, m_b, b ^ 32)));
        chk("tlast0", 64'(tl0), 64'(b == 63));
        chk("tlast1", 64'(tl1), 64'(b == 63));
        chk("tuser0", 64'(tu0), 64'(beat / 64));
        chk("tuser1", 64'(tu1), 64'(beat / 64));
        chk("busy0", 64'(busy0), 64'd1);
        if (tready) begin
          cap0[beat] = td0;
          cap1[beat] = td1;
          tucap[beat] = tu0;
          if (tl0) tlast_cnt++;
          beat++;
          if (beat == total) begin
            act = 0;
            done_pend = 1;
          end
        end else begin
          stalls++;
        end
      end
    end
  end

  task automatic start_run(input int md, input int n, input logic [15:0] a, input logic [15:0] bb);
    mode = 2'(md);
    n_sym = 3'(n);
    stf_amp = a;
    ltf_amp = bb;
    start = 1'b1;
    tlast_cnt = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (n != 0) begin
      m_mode = md;
      m_a = a;
      m_b = bb;
      total = n * 64;
      beat = 0;
      act = 1;
    end
  endtask

  task automatic run_wait(input string name);
    int n;
    n = 0;
    while ((act || done_pend) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(name, 64'(act | done_pend), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    mode = 2'd0;
    n_sym = 3'd0;
    stf_amp = 16'h0;
    ltf_amp = 16'h0;
    stalls = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_tvalid", 64'(tv0), 64'd0);
    chk("rst_tlast", 64'(tl0), 64'd0);
    chk("rst_tuser", 64'(tu0), 64'd0);
    chk("rst_done", 64'(dn0), 64'd0);
    chk("rst_tdata", 64'(td0), 64'd0);
    rstn = 1'b1;
    mon_on = 1;
    @(posedge clk);
    #1;

    start_run(0, 1, 16'h30e0, 16'h1111);
    run_wait("lstf_timeout");
    chk("lstf_bin8", 64'(cap0[8]), 64'h30e0_30e0);
    chk("lstf_bin12", 64'(cap0[12]), 64'hcf20_cf20);
    chk("lstf_bin32", 64'(cap0[32]), 64'h0);
    chk("lstf_tlasts", 64'(tlast_cnt), 64'd1);

    start_run(1, 2, 16'h2222, 16'h4000);
    run_wait("lltf_timeout");
    chk("lltf_bin6", 64'(cap0[6]), 64'h4000_0000);
    chk("lltf_bin32", 64'(cap0[32]), 64'h0);
    chk("lltf_bin4", 64'(cap0[4]), 64'h0);
    chk("lltf_bin59", 64'(cap0[59]), 64'h0);
    chk("lltf_sym1_bin6", 64'(cap0[70]), 64'h4000_0000);
    chk("lltf_tuser_first", 64'(tucap[0]), 64'd0);
    chk("lltf_tuser_last", 64'(tucap[127]), 64'd1);
    chk("lltf_tlasts", 64'(tlast_cnt), 64'd2);
    chk("order1_beat0", 64'(cap1[0]), 64'h0);
    chk("order1_beat38", 64'(cap1[38]), 64'h4000_0000);

    start_run(3, 1, 16'h0, 16'h4000);
    run_wait("htltf_timeout");
    chk("htltf_bin4", 64'(cap0[4]), 64'h4000_0000);
    chk("htltf_bin5", 64'(cap0[5]), 64'h4000_0000);
    chk("htltf_bin59", 64'(cap0[59]), 64'hc000_0000);
    chk("htltf_bin60", 64'(cap0[60]), 64'hc000_0000);

    // Stalled run: mid-run start and amplitude changes must not disturb the stream.
    rnd_rdy = 1;
    start_run(2, 3, 16'h1234, 16'h0555);
    repeat (40) @(posedge clk);
    #1;
    mode = 2'd1;
    n_sym = 3'd1;
    stf_amp = 16'h7fff;
    ltf_amp = 16'h7fff;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    run_wait("htstf_timeout");
    rnd_rdy = 0;
    chk("htstf_bin8", 64'(cap0[8]), 64'h1234_1234);
    chk("htstf_sym1_bin12", 64'(cap0[76]), 64'hedcc_edcc);
    chk("htstf_tlasts", 64'(tlast_cnt), 64'd3);
    chk("stalls_seen", 64'(stalls > 0), 64'd1);

    start_run(0, 1, 16'h0, 16'h0);
    run_wait("zero_timeout");
    chk("zero_bin8", 64'(cap0[8]), 64'h0);

    // Asynchronous reset in the middle of a symbol.
    start_run(0, 1, 16'h30e0, 16'h0);
    repeat (20) @(posedge clk);
    #2;
    rstn = 1'b0;
    act = 0;
    done_pend = 0;
    #1;
    chk("midrst_tvalid0", 64'(tv0), 64'd0);
    chk("midrst_tvalid1", 64'(tv1), 64'd0);
    chk("midrst_busy0", 64'(busy0), 64'd0);
    chk("midrst_tdata0", 64'(td0), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start_run(1, 1, 16'h0, 16'h2000);
    run_wait("restart_timeout");
    chk("restart_bin6", 64'(cap0[6]), 64'h2000_0000);

    start_run(0, 0, 16'h30e0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("nsym0_busy", 64'(busy0), 64'd0);
    chk("nsym0_tvalid", 64'(tv0), 64'd0);

    mon_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
